zebra_stripe_profiler: RTL and testbench
========================================

// Module: zebra_stripe_profiler
// PURPOSE
//  Streaming, BRAM-free successor to the capture-then-scan crossing detector.
//  Binarises the edge-filtered pixel stream against a runtime threshold.
//  Counts stripe runs per row inside NUM_BANDS horizontal bands.
//  Emits a per-frame crossing verdict, debounced across frames, on a valid/ready result port.
// PARAMETERS
//  IMG_WIDTH    640  pixels per row
//  IMG_HEIGHT   480  rows per frame
//  W            8    pixel width
//  NUM_BANDS    4    number of row bands examined
//  BAND_START   240  first row of band 0
//  BAND_PITCH   48   row distance between band starts; must be >= BAND_ROWS
//  BAND_ROWS    8    rows per band
//  MIN_RUN      4    shortest 1-run counted as a stripe, in pixels
//  MAX_RUN      120  longest 1-run counted as a stripe, in pixels
//  MIN_STRIPES  3    stripes a row needs to qualify
//  MIN_ROWS     4    qualifying rows a band needs to hit
//  MIN_BANDS    2    band hits a frame needs to be positive
//  HYST_FRAMES  2    consecutive equal frame verdicts needed to flip crossing_detected
// PORTS
//  clk                input   1          clock
//  rst_n              input   1          async active-low reset
//  x_valid            input   1          pixel valid
//  x_ready            output  1          pixel ready
//  x_data             input   W          edge-filtered pixel
//  bin_threshold      input   W          pixel is 1 when x_data >= bin_threshold
//  frame_restart      input   1          sync pulse: abandon current frame, next pixel is (0,0)
//  det_valid          output  1          frame result available
//  det_ready          input   1          result consumer ready
//  crossing_detected  output  1          debounced verdict
//  stripe_count       output  8          max qualifying-run count of any band row, saturating at 255
//  band_hits          output  NUM_BANDS  per-band hit flags for the frame
//  det_overrun        output  1          1-cycle pulse when an unconsumed result is overwritten
// BEHAVIOUR
//  Reset: all outputs 0; col/row/run/band counters 0; hysteresis counter 0; FSM in IDLE.
//  - x_ready goes 1 on the first clk edge after rst_n deasserts and stays 1.
//  - Input is never stalled; a pixel is accepted on x_valid && x_ready.
//  Position: col/row advance per accepted pixel; col wraps at IMG_WIDTH-1; row wraps at IMG_HEIGHT-1.
//  FSM states and transitions:
//  - IDLE -> SCAN on the first accepted pixel.
//  - SCAN -> CLOSE on acceptance of pixel (IMG_WIDTH-1, IMG_HEIGHT-1).
//  - CLOSE -> IDLE after one cycle.
//  - In CLOSE, per-band flags, stripe_count and hysteresis are updated. det_valid is asserted from the cycle after CLOSE.
//  Latency: last pixel accepted at cycle N; results and det_valid are valid at N+2.
//  Run tracking, only in band rows (BAND_START + b*BAND_PITCH + 0..BAND_ROWS-1):
//  - run_len increments on a 1 pixel and saturates at MAX_RUN+1.
//  - A run closes on a 0 pixel or at col IMG_WIDTH-1; a 1 on the last column closes the run including that pixel.
//  - On close, the row stripe counter increments if MIN_RUN <= run_len <= MAX_RUN. run_len then clears.
//  - Runs never span rows.
//  Row end, in a band row:
//  - row_stripes >= MIN_STRIPES increments that band's qualifying-row counter, which saturates.
//  - The frame max of row_stripes is updated.
//  Frame verdict: positive when popcount(band_hit) >= MIN_BANDS, where band_hit[b] = rows_b >= MIN_ROWS.
//  Hysteresis:
//  - A verdict that differs from crossing_detected increments a counter; an equal verdict clears it.
//  - When the counter reaches HYST_FRAMES, crossing_detected flips and the counter clears.
//  - HYST_FRAMES=1 gives an immediate follow.
//  Result handshake:
//  - det_valid holds, with stable outputs, until det_valid && det_ready; it drops the next cycle.
//  - If CLOSE occurs while det_valid is still pending, the outputs are overwritten, det_valid stays 1, and det_overrun pulses.
//  - If det_ready coincides with CLOSE, the old result is consumed, the new one is loaded, and there is no overrun.
//  frame_restart:
//  - Clears col, row, run, row and band counters and the frame max, and sets the FSM to IDLE.
//  - Leaves det_* outputs and hysteresis untouched.
//  - If frame_restart coincides with an accepted pixel, that pixel is position (0,0).
//  - A frame cut short by frame_restart produces no result.
//  Async reset mid-frame discards everything; the next pixel after reset is (0,0).
//  Elaboration errors when BAND_PITCH < BAND_ROWS or the last band row >= IMG_HEIGHT.
// TESTING
//  Test parameters: IMG 32x16, BAND_START=4, PITCH=6, ROWS=2, NUM_BANDS=2, MIN_BANDS=2, MIN_ROWS=2, HYST_FRAMES=2.
//  1. Band rows with four 4-px runs; 2 frames -> frame1 band_hits=2'b11, crossing 0; frame2 crossing 1; stripe_count=4.
//  2. Run of 31 px with MAX_RUN=30, plus a 3-px run with MIN_RUN=4 -> neither counted; stripe_count=0.
//  3. Run ending at col 31 -> counted; col-31 pixel=1 then row+1 col0=1 -> two separate runs.
//  4. det_ready=0 over two frames -> det_overrun pulses once at second CLOSE; det_valid held; outputs reflect frame 2.
//  5. frame_restart at row 9 then full frame -> exactly one result at N+2 after its last pixel.
//  6. rst_n low mid-frame at row 5 -> all outputs 0 immediately; x_ready 1 on the first edge after release; result follows a clean frame.

Source files
------------

// File: rtl/zebra_stripe_profiler.sv
// Streaming zebra-crossing detector: binarises pixels, counts stripe runs in a set of
// horizontal bands and reports a hysteresis-filtered verdict once per frame.
module zebra_stripe_profiler #(
   parameter int IMG_WIDTH   = 640,
   parameter int IMG_HEIGHT  = 480,
   parameter int W           = 8,
   parameter int NUM_BANDS   = 4,
   parameter int BAND_START  = 240,
   parameter int BAND_PITCH  = 48,
   parameter int BAND_ROWS   = 8,
   parameter int MIN_RUN     = 4,
   parameter int MAX_RUN     = 120,
   parameter int MIN_STRIPES = 3,
   parameter int MIN_ROWS    = 4,
   parameter int MIN_BANDS   = 2,
   parameter int HYST_FRAMES = 2
) (
   input  logic                 clk,
   input  logic                 rst_n,
   input  logic                 x_valid,
   output logic                 x_ready,
   input  logic [W-1:0]         x_data,
   input  logic [W-1:0]         bin_threshold,
   input  logic                 frame_restart,
   output logic                 det_valid,
   input  logic                 det_ready,
   output logic                 crossing_detected,
   output logic [7:0]           stripe_count,
   output logic [NUM_BANDS-1:0] band_hits,
   output logic                 det_overrun
);

   localparam int COL_W  = (IMG_WIDTH  > 1) ? $clog2(IMG_WIDTH)  : 1;
   localparam int ROW_W  = (IMG_HEIGHT > 1) ? $clog2(IMG_HEIGHT) : 1;
   localparam int RUN_W  = $clog2(MAX_RUN + 2);
   localparam int RC_MAXV = (BAND_ROWS > MIN_ROWS) ? BAND_ROWS : MIN_ROWS;
   localparam int RC_W   = $clog2(RC_MAXV + 1);
   localparam int HC_W   = $clog2(HYST_FRAMES + 1);
   localparam int HIT_W  = $clog2(NUM_BANDS + 1);
   localparam int LAST_BAND_ROW = BAND_START + (NUM_BANDS - 1) * BAND_PITCH + BAND_ROWS - 1;

   localparam logic [COL_W-1:0] LAST_COL  = COL_W'(IMG_WIDTH - 1);
   localparam logic [ROW_W-1:0] LAST_ROW  = ROW_W'(IMG_HEIGHT - 1);
   localparam logic [RUN_W-1:0] RUN_SAT   = RUN_W'(MAX_RUN + 1);
   localparam logic [RC_W-1:0]  RC_MAX    = {RC_W{1'b1}};
   localparam logic [HC_W-1:0]  HYST_LAST = HC_W'(HYST_FRAMES - 1);

   localparam logic [1:0] ST_IDLE  = 2'd0;
   localparam logic [1:0] ST_SCAN  = 2'd1;
   localparam logic [1:0] ST_CLOSE = 2'd2;

   generate
      if (BAND_PITCH < BAND_ROWS) begin : g_pitch_check
         $error("zebra_stripe_profiler: BAND_PITCH must be >= BAND_ROWS");
      end
      if (LAST_BAND_ROW >= IMG_HEIGHT) begin : g_height_check
         $error("zebra_stripe_profiler: last band row lies outside the frame");
      end
   endgenerate

   logic [1:0]             state;
   logic [COL_W-1:0]       col;
   logic [ROW_W-1:0]       row;
   logic [RUN_W-1:0]       run_len;
   logic [7:0]             row_stripes;
   logic [RC_W-1:0]        band_rows [NUM_BANDS];
   logic [7:0]             frame_max;
   logic [HC_W-1:0]        hyst_cnt;

   logic                   accept;
   logic [COL_W-1:0]       cur_col;
   logic [ROW_W-1:0]       cur_row;
   logic [RUN_W-1:0]       cur_run;
   logic [7:0]             cur_stripes;
   logic                   pix_one;
   logic                   last_col;
   logic                   last_row;
   logic [RUN_W-1:0]       run_next;
   logic                   run_close;
   logic                   stripe_hit;
   logic [7:0]             stripes_next;
   logic                   row_qual;
   logic [NUM_BANDS-1:0]   in_band;
   logic                   band_row;
   logic [NUM_BANDS-1:0]   band_hit;
   logic [HIT_W-1:0]       hit_count;
   logic                   verdict;

   assign accept   = x_valid && x_ready;
   assign band_row = |in_band;

   // A restart makes the coincident pixel the first of a fresh frame, so all
   // per-row state is seen as cleared when processing it.
   always_comb begin
      cur_col      = frame_restart ? '0 : col;
      cur_row      = frame_restart ? '0 : row;
      cur_run      = frame_restart ? '0 : run_len;
      cur_stripes  = frame_restart ? '0 : row_stripes;
      pix_one      = x_data >= bin_threshold;
      last_col     = cur_col == LAST_COL;
      last_row     = cur_row == LAST_ROW;
      run_next     = cur_run;
      if (pix_one && cur_run != RUN_SAT) run_next = cur_run + 1'b1;
      run_close    = !pix_one || last_col;
      stripe_hit   = run_close && (run_next >= RUN_W'(MIN_RUN)) && (run_next <= RUN_W'(MAX_RUN));
      stripes_next = cur_stripes;
      if (stripe_hit && cur_stripes != 8'hFF) stripes_next = cur_stripes + 8'd1;
      row_qual     = stripes_next >= 8'(MIN_STRIPES);
   end

   for (genvar b = 0; b < NUM_BANDS; b++) begin : g_band
      localparam int LO = BAND_START + b * BAND_PITCH;
      localparam int HI = LO + BAND_ROWS - 1;
      assign in_band[b]  = (cur_row >= ROW_W'(LO)) && (cur_row <= ROW_W'(HI));
      assign band_hit[b] = band_rows[b] >= RC_W'(MIN_ROWS);
   end

   always_comb begin
      hit_count = '0;
      for (int b = 0; b < NUM_BANDS; b++) hit_count = hit_count + HIT_W'(band_hit[b]);
      verdict = hit_count >= HIT_W'(MIN_BANDS);
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) x_ready <= 1'b0;
      else        x_ready <= 1'b1;
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         col <= '0;
         row <= '0;
      end else if (accept) begin
         col <= last_col ? '0 : cur_col + 1'b1;
         if (last_col) row <= last_row ? '0 : cur_row + 1'b1;
         else          row <= cur_row;
      end else if (frame_restart) begin
         col <= '0;
         row <= '0;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         run_len     <= '0;
         row_stripes <= '0;
      end else if (accept && band_row && !last_col) begin
         run_len     <= run_close ? '0 : run_next;
         row_stripes <= stripes_next;
      end else if (accept || frame_restart) begin
         run_len     <= '0;
         row_stripes <= '0;
      end
   end

   // Frame accumulators are read in CLOSE and cleared there for the next frame.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         for (int b = 0; b < NUM_BANDS; b++) band_rows[b] <= '0;
         frame_max <= '0;
      end else if (frame_restart || state == ST_CLOSE) begin
         for (int b = 0; b < NUM_BANDS; b++) band_rows[b] <= '0;
         frame_max <= '0;
      end else if (accept && band_row && last_col) begin
         for (int b = 0; b < NUM_BANDS; b++) begin
            if (in_band[b] && row_qual && band_rows[b] != RC_MAX)
               band_rows[b] <= band_rows[b] + 1'b1;
         end
         if (stripes_next > frame_max) frame_max <= stripes_next;
      end
   end

   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state <= ST_IDLE;
      end else if (frame_restart) begin
         state <= accept ? ST_SCAN : ST_IDLE;
      end else begin
         case (state)
            ST_IDLE:  if (accept) state <= ST_SCAN;
            ST_SCAN:  if (accept && last_col && last_row) state <= ST_CLOSE;
            ST_CLOSE: state <= ST_IDLE;
            default:  state <= ST_IDLE;
         endcase
      end
   end

   // Result register: loaded in CLOSE, held until consumed; an unconsumed
   // result being replaced raises a one-cycle overrun flag.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         det_valid         <= 1'b0;
         det_overrun       <= 1'b0;
         crossing_detected <= 1'b0;
         stripe_count      <= '0;
         band_hits         <= '0;
         hyst_cnt          <= '0;
      end else begin
         det_overrun <= 1'b0;
         if (state == ST_CLOSE) begin
            det_valid    <= 1'b1;
            det_overrun  <= det_valid && !det_ready;
            stripe_count <= frame_max;
            band_hits    <= band_hit;
            if (verdict != crossing_detected) begin
               if (hyst_cnt == HYST_LAST) begin
                  crossing_detected <= verdict;
                  hyst_cnt          <= '0;
               end else begin
                  hyst_cnt <= hyst_cnt + 1'b1;
               end
            end else begin
               hyst_cnt <= '0;
            end
         end else if (det_valid && det_ready) begin
            det_valid <= 1'b0;
         end
      end
   end

endmodule

// File: tb/tb_zebra_stripe_profiler.sv
// Directed bench for zebra_stripe_profiler on a 32x16 image with two 2-row bands;
// expected frame results come from a reference model and are checked via a scoreboard.
module tb_zebra_stripe_profiler;

   localparam int IW = 32;
   localparam int IH = 16;
   localparam int MIN_RUN_P = 4;
   localparam int MAX_RUN_P = 30;

   typedef struct packed {
      logic       crossing;
      logic [7:0] stripes;
      logic [1:0] hits;
   } exp_t;

   logic       clk;
   logic       rst_n;
   logic       x_valid;
   logic       x_ready;
   logic [7:0] x_data;
   logic [7:0] bin_threshold;
   logic       frame_restart;
   logic       det_valid;
   logic       det_ready;
   logic       crossing_detected;
   logic [7:0] stripe_count;
   logic [1:0] band_hits;
   logic       det_overrun;

   int   test_count = 0;
   int   fail_count = 0;
   int   overrun_seen = 0;
   int   exp_overruns = 0;
   int   results_seen = 0;
   exp_t sb_q[$];
   exp_t last_exp;
   logic exp_cross;
   int   exp_hcnt;
   logic [7:0]  thr;
   logic [31:0] img [IH];

   zebra_stripe_profiler #(
      .IMG_WIDTH(IW), .IMG_HEIGHT(IH), .W(8), .NUM_BANDS(2),
      .BAND_START(4), .BAND_PITCH(6), .BAND_ROWS(2),
      .MIN_RUN(MIN_RUN_P), .MAX_RUN(MAX_RUN_P), .MIN_STRIPES(3),
      .MIN_ROWS(2), .MIN_BANDS(2), .HYST_FRAMES(2)
   ) dut (
      .clk(clk), .rst_n(rst_n), .x_valid(x_valid), .x_ready(x_ready),
      .x_data(x_data), .bin_threshold(bin_threshold), .frame_restart(frame_restart),
      .det_valid(det_valid), .det_ready(det_ready),
      .crossing_detected(crossing_detected), .stripe_count(stripe_count),
      .band_hits(band_hits), .det_overrun(det_overrun)
   );

   initial begin
      clk = 1'b0;
      forever #5 clk = ~clk;
   end

   initial begin
      #1000000;
      $display("[TB] FAIL global_timeout: simulation did not finish in time");
      $fatal(1, "[TB] timeout");
   end

   task automatic check_output(input string tag, input logic [31:0] obs, input logic [31:0] expv);
      test_count++;
      assert (obs === expv) else begin
         fail_count++;
         $error("[TB] FAIL %s: observed %0h expected %0h", tag, obs, expv);
      end
   endtask

   function automatic logic [31:0] run_mask(input int s, input int len);
      logic [31:0] one = 32'h1;
      return ((one << len) - 32'h1) << s;
   endfunction

   function automatic int count_row(input logic [31:0] bits);
      int run = 0;
      int cnt = 0;
      for (int c = 0; c < IW; c++) begin
         if (bits[c] && run < MAX_RUN_P + 1) run++;
         if (!bits[c] || c == IW - 1) begin
            if (run >= MIN_RUN_P && run <= MAX_RUN_P) cnt++;
            run = 0;
         end
      end
      return cnt;
   endfunction

   function automatic logic [7:0] pix_val(input logic one, input int c);
      if (one) return (c % 2 == 1) ? thr : 8'd255;
      if (c % 3 == 0) return thr - 8'd1;
      return 8'($urandom_range(0, int'(thr) - 1));
   endfunction

   task automatic set_pattern(input logic [31:0] r4, input logic [31:0] r5,
                              input logic [31:0] r10, input logic [31:0] r11);
      for (int r = 0; r < IH; r++) img[r] = $urandom();
      img[4] = r4; img[5] = r5; img[10] = r10; img[11] = r11;
   endtask

   task automatic apply_stimulus(input int full_rows, input int extra, input logic restart_first);
      logic first;
      int   ncol;
      first = restart_first;
      for (int r = 0; r <= full_rows && r < IH; r++) begin
         ncol = (r < full_rows) ? IW : extra;
         for (int c = 0; c < ncol; c++) begin
            x_valid       = 1'b1;
            x_data        = pix_val(img[r][c], c);
            frame_restart = first;
            first         = 1'b0;
            @(negedge clk);
         end
      end
      x_valid       = 1'b0;
      frame_restart = 1'b0;
   endtask

   task automatic push_expect(input logic overwrite);
      exp_t e;
      int   rows_b;
      int   s;
      int   mx = 0;
      int   hits = 0;
      logic v;
      for (int b = 0; b < 2; b++) begin
         rows_b = 0;
         for (int k = 0; k < 2; k++) begin
            s = count_row(img[4 + 6 * b + k]);
            if (s >= 3) rows_b++;
            if (s > mx) mx = s;
         end
         e.hits[b] = (rows_b >= 2);
         if (rows_b >= 2) hits++;
      end
      v = (hits >= 2);
      if (v != exp_cross) begin
         exp_hcnt++;
         if (exp_hcnt == 2) begin
            exp_cross = v;
            exp_hcnt  = 0;
         end
      end else begin
         exp_hcnt = 0;
      end
      e.crossing = exp_cross;
      e.stripes  = 8'(mx);
      if (overwrite && sb_q.size() != 0) begin
         void'(sb_q.pop_back());
         exp_overruns++;
      end
      sb_q.push_back(e);
      last_exp = e;
   endtask

   task automatic wait_drain(input string tag, input int budget);
      int n = 0;
      while (sb_q.size() != 0 && n < budget) begin
         @(negedge clk);
         n++;
      end
      check_output(tag, 32'(sb_q.size()), 32'd0);
   endtask

   always begin : monitor
      exp_t me;
      @(negedge clk);
      #2;
      if (det_overrun) overrun_seen++;
      if (det_valid && det_ready) begin
         check_output("sb_nonempty", 32'(sb_q.size() != 0), 32'd1);
         if (sb_q.size() != 0) begin
            me = sb_q.pop_front();
            results_seen++;
            check_output("sb_crossing", 32'(crossing_detected), 32'(me.crossing));
            check_output("sb_stripe_count", 32'(stripe_count), 32'(me.stripes));
            check_output("sb_band_hits", 32'(band_hits), 32'(me.hits));
         end
      end
   end

   initial begin
      logic [31:0] four_runs;
      logic [31:0] five_runs;
      int          r0;
      rst_n = 1'b0; x_valid = 1'b0; x_data = '0; frame_restart = 1'b0; det_ready = 1'b1;
      thr = 8'd100; bin_threshold = thr;
      exp_cross = 1'b0; exp_hcnt = 0;
      four_runs = run_mask(0, 4) | run_mask(5, 4) | run_mask(10, 4) | run_mask(15, 4);
      five_runs = four_runs | run_mask(20, 4);

      repeat (3) @(negedge clk);
      check_output("reset_outputs",
         32'({x_ready, det_valid, crossing_detected, stripe_count, band_hits, det_overrun}), 32'd0);
      rst_n = 1'b1;
      #1;
      check_output("x_ready_before_edge", 32'(x_ready), 32'd0);
      @(negedge clk);
      check_output("x_ready_after_edge", 32'(x_ready), 32'd1);

      // four 4-px runs in every band row, two frames for the hysteresis to flip
      set_pattern(four_runs, four_runs, four_runs, four_runs);
      apply_stimulus(IH, 0, 1'b0);
      push_expect(1'b0);
      set_pattern(four_runs, four_runs, four_runs, four_runs);
      apply_stimulus(IH, 0, 1'b0);
      push_expect(1'b0);
      wait_drain("t1_drain", 20);
      check_output("t1_crossing", 32'(crossing_detected), 32'd1);
      check_output("t1_stripes", 32'(stripe_count), 32'd4);

      // over-long and too-short runs are ignored
      thr = 8'd60; bin_threshold = thr;
      set_pattern(run_mask(0, 31), run_mask(0, 3) | run_mask(8, 3) | run_mask(16, 3), 32'h0, 32'h0);
      apply_stimulus(IH, 0, 1'b0);
      push_expect(1'b0);
      wait_drain("t2_drain", 20);
      check_output("t2_stripes", 32'(stripe_count), 32'd0);
      check_output("t2_hits", 32'(band_hits), 32'd0);

      // runs closing on the last column, and no run carried across rows
      thr = 8'd100; bin_threshold = thr;
      set_pattern(run_mask(0, 4) | run_mask(8, 4) | run_mask(26, 6),
                  run_mask(0, 2) | run_mask(5, 4) | run_mask(12, 4) | run_mask(20, 4),
                  run_mask(0, 4) | run_mask(8, 4) | run_mask(26, 6),
                  run_mask(0, 2) | run_mask(5, 4) | run_mask(12, 4) | run_mask(20, 4));
      apply_stimulus(IH, 0, 1'b0);
      push_expect(1'b0);
      wait_drain("t3_drain", 20);
      check_output("t3_stripes", 32'(stripe_count), 32'd3);
      check_output("t3_hits", 32'(band_hits), 32'd3);

      // consumer stalled over two frames: second result overwrites the first
      det_ready = 1'b0;
      set_pattern(run_mask(0, 31), 32'h0, 32'h0, 32'h0);
      apply_stimulus(IH, 0, 1'b0);
      push_expect(1'b0);
      set_pattern(five_runs, five_runs, 32'h0, 32'h0);
      apply_stimulus(IH, 0, 1'b0);
      push_expect(1'b1);
      repeat (3) @(negedge clk);
      check_output("t4_valid_held", 32'(det_valid), 32'd1);
      check_output("t4_overrun_count", 32'(overrun_seen), 32'd1);
      check_output("t4_stripes", 32'(stripe_count), 32'd5);
      check_output("t4_hits", 32'(band_hits), 32'd1);
      check_output("t4_crossing", 32'(crossing_detected), 32'd0);
      det_ready = 1'b1;
      wait_drain("t4_drain", 20);
      check_output("t4_valid_dropped", 32'(det_valid), 32'd0);

      // abandoned frame followed by a restart-aligned full frame
      r0 = results_seen;
      set_pattern(five_runs, five_runs, five_runs, five_runs);
      apply_stimulus(9, 10, 1'b0);
      set_pattern(four_runs, four_runs, four_runs, four_runs);
      apply_stimulus(IH, 0, 1'b1);
      check_output("t5_valid_n1", 32'(det_valid), 32'd0);
      push_expect(1'b0);
      @(negedge clk);
      check_output("t5_valid_n2", 32'(det_valid), 32'd1);
      check_output("t5_stripes", 32'(stripe_count), 32'(last_exp.stripes));
      check_output("t5_hits", 32'(band_hits), 32'(last_exp.hits));
      check_output("t5_crossing", 32'(crossing_detected), 32'(last_exp.crossing));
      repeat (6) @(negedge clk);
      check_output("t5_one_result", 32'(results_seen - r0), 32'd1);

      // asynchronous reset in the middle of a frame
      set_pattern(five_runs, five_runs, five_runs, five_runs);
      apply_stimulus(5, 7, 1'b0);
      rst_n = 1'b0;
      #1;
      check_output("t6_reset_outputs",
         32'({x_ready, det_valid, crossing_detected, stripe_count, band_hits, det_overrun}), 32'd0);
      exp_cross = 1'b0; exp_hcnt = 0;
      sb_q.delete();
      @(negedge clk);
      @(negedge clk);
      rst_n = 1'b1;
      #1;
      check_output("t6_x_ready_before_edge", 32'(x_ready), 32'd0);
      @(negedge clk);
      check_output("t6_x_ready_after_edge", 32'(x_ready), 32'd1);
      set_pattern(four_runs, four_runs, four_runs, four_runs);
      apply_stimulus(IH, 0, 1'b0);
      push_expect(1'b0);
      wait_drain("t6_drain", 20);
      check_output("t6_hits", 32'(band_hits), 32'd3);
      check_output("t6_crossing", 32'(crossing_detected), 32'd0);

      check_output("total_overruns", 32'(overrun_seen), 32'(exp_overruns));
      $display("[TB] %0d tests run, %0d failed", test_count, fail_count);
      $finish;
   end

endmodule
